// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: default address and
// instruction widths, the fetch FSM state encoding and the address/instruction
// typedefs at default width.
// No ports.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int INSTR_W_DEF = 17;

  typedef logic [ADDR_W_DEF-1:0]  addr_t;
  typedef logic [INSTR_W_DEF-1:0] instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_unit_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc
// Program counter register with increment (wraps modulo 2^ADDR_W) and branch
// target load. Load has priority over increment.
// Build option: FETCH_REL_BRANCH_EN -- when defined, the branch target is
// instr_pc plus the sign-extended branch_target offset; otherwise the branch
// target is taken as an absolute address.
// Ports:
//   clk, nReset          clock, asynchronous active-low reset
//   inc_en               advance PC by one
//   load_en              load PC with the branch target
//   branch_target        absolute target or signed offset
//   instr_pc             address of the instruction currently in decode
//   pc                   current program counter
// -----------------------------------------------------------------------------
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              inc_en,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] target_s;

`ifdef FETCH_REL_BRANCH_EN
  // Relative target: offset and PC share one width, so the modulo-2^ADDR_W
  // sum already equals adding the sign-extended offset.
  always_comb begin
    target_s = instr_pc + branch_target;
  end
`else
  logic unused_instr_pc_s;
  assign unused_instr_pc_s = ^instr_pc;

  // Absolute target: branch_target is the destination address itself.
  always_comb begin
    target_s = branch_target;
  end
`endif

  // Next PC selection: branch load beats sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = target_s;
    end else if (inc_en) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pc_q <= {ADDR_W{1'b0}};
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Single-issue instruction fetch stage. Drives the program memory address from
// the PC, captures the returned instruction into a valid/ready register for
// decode, and handles branch redirects (one-bubble flush) and halt.
// Build option: FETCH_REL_BRANCH_EN selects PC-relative branch targets
// (handled inside fetch_pc); default is absolute targets.
// Ports:
//   clk, nReset                 clock, asynchronous active-low reset
//   address  (out)              program memory address (= PC)
//   I        (in)               instruction read from address
//   instr, instr_pc, instr_valid (out)  registered instruction to decode
//   instr_ready (in)            decode accepts instr this cycle
//   branch_en, branch_target    redirect request and target
//   halt (in) / halted (out)    stop request / FSM is in HALT
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               nReset,
  output logic [ADDR_W-1:0]  address,
  input  logic [INSTR_W-1:0] I,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic               halted
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic               pc_inc_s;
  logic               pc_load_s;
  logic [ADDR_W-1:0]  pc_s;

  fetch_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk           (clk),
    .nReset        (nReset),
    .inc_en        (pc_inc_s),
    .load_en       (pc_load_s),
    .branch_target (branch_target),
    .instr_pc      (instr_pc_q),
    .pc            (pc_s)
  );

  // FSM next state and instruction register update.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    pc_inc_s      = 1'b0;
    pc_load_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (branch_en) begin
          // Redirect wins over fetch and stall; the in-flight instr is dropped.
          pc_load_s     = 1'b1;
          instr_valid_d = 1'b0;
          if (halt) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (halt) begin
          // No new fetch; a held instr drains once decode takes it.
          state_d = ST_HALT;
          if (instr_ready) begin
            instr_valid_d = 1'b0;
          end else begin
            instr_valid_d = instr_valid_q;
          end
        end else if (!instr_valid_q || instr_ready) begin
          instr_d       = I;
          instr_pc_d    = pc_s;
          instr_valid_d = 1'b1;
          pc_inc_s      = 1'b1;
        end else begin
          instr_valid_d = instr_valid_q;
        end
      end
      ST_HALT: begin
        if (branch_en) begin
          pc_load_s     = 1'b1;
          instr_valid_d = 1'b0;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
        end else begin
          instr_valid_d = instr_valid_q;
        end
        if (halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        instr_valid_d = 1'b0;
      end
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // FSM state and decode-facing output registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= ST_IDLE;
      instr_q       <= {INSTR_W{1'b0}};
      instr_pc_q    <= {ADDR_W{1'b0}};
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign address     = pc_s;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 4: program memory address width.
REQ-002 Parameter INSTR_W, default 17: instruction width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 address  output  ADDR_W  program memory address; equals the internal PC combinationally.
REQ-006 I  input  INSTR_W  instruction returned combinationally by program memory for address.
REQ-007 instr  output  INSTR_W  registered instruction presented to decode.
REQ-008 instr_pc  output  ADDR_W  address from which instr was fetched.
REQ-009 instr_valid  output  1  instr/instr_pc valid.
REQ-010 instr_ready  input  1  decode accepts instr this cycle.
REQ-011 branch_en  input  1  redirect request.
REQ-012 branch_target  input  ADDR_W  redirect target (absolute, or signed offset per REQ-027).
REQ-013 halt  input  1  stop fetching (level).
REQ-014 halted  output  1  FSM in HALT.

Function
REQ-015 FSM states: IDLE, FETCH, HALT; encoding is an enum from the package.
REQ-016 IDLE -> FETCH on the first clock after reset release if halt=0, else IDLE -> HALT.
REQ-017 In FETCH, a fetch occurs when instr_valid=0 or instr_ready=1: instr<=I, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
REQ-018 Fetch-to-instr latency is one cycle; sustained throughput one instruction per cycle while instr_ready=1.
REQ-019 When instr_valid=1 and instr_ready=0, instr, instr_pc, instr_valid and PC hold unchanged.
REQ-020 PC increment wraps modulo 2^ADDR_W (15 -> 0 at default width), no flag.
REQ-021 branch_en=1 in FETCH or HALT: PC<=target address, instr_valid<=0 next cycle (flush), overriding REQ-017 and REQ-019; no fetch that cycle.
REQ-022 First fetch from the target occurs the cycle after a branch; branch penalty exactly one bubble.
REQ-023 halt=1 in FETCH: no new fetch; FSM -> HALT; an instr held valid remains until accepted, then instr_valid<=0.
REQ-024 In HALT, halt=0 returns to FETCH next cycle, resuming at current PC; halted=1 only in HALT.
REQ-025 Simultaneous halt and branch_en: branch updates PC and flushes, FSM still enters/stays HALT.

Reset
REQ-026 nReset=0 asynchronously forces PC=0, instr=0, instr_pc=0, instr_valid=0, halted=0, state IDLE; reset asserted mid-fetch or mid-branch discards all in-flight state.

Configuration
REQ-027 FETCH_REL_BRANCH_EN defined: target = instr_pc + sign-extended branch_target, modulo 2^ADDR_W; undefined: target = branch_target (absolute).

Structure
REQ-028 Package fetch_pkg holds ADDR_W/INSTR_W defaults, the FSM state enum and the addr_t/instr_t typedefs.
REQ-029 One sub-module, fetch_pc, holds the PC register, increment/wrap and target computation; FSM and instruction register stay in fetch_unit.

Verification
REQ-030 Reset release, instr_ready=1, ROM word n = n*3: address 0,1,2,... each cycle; instr_pc/instr follow one cycle later; 15 wraps to 0.
REQ-031 instr_ready=0 for 3 cycles with instr_pc=4: instr, instr_pc=4, address=5 held; instr_pc=5 one cycle after ready returns.
REQ-032 branch_en with target 9 while instr_pc=2: next cycle instr_valid=0, address=9; following cycle instr_pc=9.
REQ-033 FETCH_REL_BRANCH_EN, instr_pc=14, branch_target=4'b0011: address=1 next cycle; offset 4'b1110 from instr_pc=1: address=15.
REQ-034 halt while valid, ready=0: halted=1, instr held; ready=1 -> instr_valid=0; halt=0 -> fetch resumes at held PC.
REQ-035 nReset pulsed mid-stream at instr_pc=7: immediately instr_valid=0, address=0; IDLE one cycle, then fetch from 0.
